mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control FSM for the LoongArch-subset core (add.w, addi.w, lu12i.w, ld.w, st.w, bne). It sequences each instruction through fetch, decode, execute, memory and write-back. It generates the IR/PC/register-file/data-memory write enables that the combinational decoder does not drive. It sits between the instruction register and the datapath: it consumes the IR word and the branch unit's `br_taken`, and drives the datapath's strobes.

## Interface
- `RESET_PC`, default 32'h1c00_0000: value the datapath PC loads on reset. Forwarded on `pc_rst_val` so the PC register and the FSM share one constant.
- `clk`  input  1  core clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `instr`  input  32  current IR contents; sampled at the end of ID only.
- `br_taken`  input  1  branch-unit result for the latched instruction; valid in EX.
- `ir_we`  output  1  IR load strobe.
- `pc_we`  output  1  PC update strobe.
- `npc_sel`  output  1  0: PC+4, 1: branch target (PC+imm).
- `rf_we`  output  1  register-file write strobe.
- `mem_we`  output  1  data-memory write strobe.
- `state`  output  3  current FSM state encoding, for debug.
- `halted`  output  1  illegal instruction seen; core frozen.
- `pc_rst_val`  output  32  equals `RESET_PC`.
- `instret`  output  32  retired-instruction count (see Configuration).
- `cycles`  output  32  cycles since reset (see Configuration).

## Operation
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Values 6 and 7 go to IF on the next edge.
- **IF:** `ir_we`=1. Next state is ID.
- **ID:** classify `instr` and register the class (ADD, ADDI, LUI, LD, ST, BNE, ILL). Later states use only the registered class, so IR changes after ID are ignored.
- Class match patterns:
  - ADD: `instr[31:15]`=17'b000000_0000_01_00000
  - ADDI: `instr[31:22]`=10'b000000_1010
  - LUI: `instr[31:25]`=7'b000101_0
  - LD: `instr[31:22]`=10'b001010_0010
  - ST: `instr[31:22]`=10'b001010_0110
  - BNE: `instr[31:26]`=6'b010111
  - Anything else is ILL.
- ID transitions: ILL goes to HALT; every other class goes to EX.
- **EX:**
  - BNE: `pc_we`=1, `npc_sel`=`br_taken`, then IF.
  - LD or ST: go to MEM.
  - ADD, ADDI or LUI: go to WB.
- **MEM:**
  - ST: `mem_we`=1, `pc_we`=1, `npc_sel`=0, then IF.
  - LD: go to WB (the DM read completes this cycle).
- **WB:** `rf_we`=1, `pc_we`=1, `npc_sel`=0, then IF. The write to r0 is suppressed by the register file, not here.
- **HALT:** all strobes 0, `halted`=1. Only `rst` leaves this state.
- Strobes are Moore outputs decoded from state plus registered class. The one exception is `npc_sel`, which also depends combinationally on `br_taken` in EX.
- At most one of `rf_we`/`mem_we` is high in any cycle. `pc_we` is high exactly once per retired instruction.

## Timing
- Cycles per instruction: ADD/ADDI/LUI 4 (IF,ID,EX,WB); LD 5; ST 4; BNE 3.
- While `rst` is high: state=IF, class register=ILL, `halted`=0, counters=0, and all strobes are forced to 0 (including `ir_we`).
- First `ir_we` occurs in the first cycle after `rst` deasserts.
- `rst` asserted mid-instruction: the state is abandoned immediately and no strobe fires in that cycle or afterwards until release. The instruction restarts from IF.
- `br_taken` is ignored outside EX-with-BNE. `npc_sel`=0 whenever `pc_we`=0.
- An ILL class reaches HALT at the edge ending ID. No PC update occurs for the illegal instruction, so the PC still points at it.

## Configuration
- `MC_PERF_CNT_EN` defined:
  - `cycles` increments every cycle after reset, including HALT.
  - `instret` increments on each cycle with `pc_we`=1.
  - Both wrap from 32'hFFFF_FFFF to 0 and are cleared by `rst`.
- Not defined: both ports are present and tied to 32'h0, with no counter flops.

## Test plan
- **ALU sequence:** reset, then IR = addi.w r1,r0,5 (32'h02801401).
  - `ir_we`@1, EX@3, `rf_we`/`pc_we`@4, `npc_sel`=0.
  - `instret`=1 after cycle 4 (macro on).
- **Load/store:**
  - ld.w (32'h28800020): `rf_we` in the 5th cycle, `mem_we` never asserted.
  - st.w (32'h29800020): `mem_we`=1 and `pc_we`=1 in cycle 4, `rf_we` never asserted.
- **BNE:** IR=32'h5C000820.
  - With `br_taken`=1 in EX: `pc_we`=1, `npc_sel`=1 in cycle 3, then IF.
  - With `br_taken`=0: `npc_sel`=0.
  - Toggling `br_taken` in IF/ID/WB has no effect.
- **Illegal:** IR=32'hFFFF_FFFF.
  - State reaches 5 after ID, `halted`=1, no `pc_we`.
  - Stays halted 100 cycles; `cycles` keeps counting while `instret` stays frozen.
  - `rst` clears it back to IF.
- **Mid-op reset:** assert `rst` during MEM of ld.w.
  - All strobes 0 that cycle, and `rf_we` never fires.
  - After release, IF and `ir_we` follow in the next cycle; counters read 0.
- **Macro off:** rerun the ALU scenario; `instret` and `cycles` stay 32'h0 throughout.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the LoongArch-subset core.
// Optional performance counters (cycles, instret) are built only when MC_PERF_CNT_EN is defined.
module mc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic        npc_sel,
  output logic        rf_we,
  output logic        mem_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] pc_rst_val,
  output logic [31:0] instret,
  output logic [31:0] cycles
);

  // state | meaning
  // IF    | IR loads the fetched word
  // ID    | instruction class is decoded and latched
  // EX    | branch resolves; others choose MEM or WB
  // MEM   | store writes memory; load read completes
  // WB    | register file written, PC advanced
  // HALT  | illegal instruction seen, core frozen until reset
  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [2:0] C_ADD  = 3'd0;
  localparam logic [2:0] C_ADDI = 3'd1;
  localparam logic [2:0] C_LUI  = 3'd2;
  localparam logic [2:0] C_LD   = 3'd3;
  localparam logic [2:0] C_ST   = 3'd4;
  localparam logic [2:0] C_BNE  = 3'd5;
  localparam logic [2:0] C_ILL  = 3'd7;

  logic [2:0] state_q, state_d;
  logic [2:0] cls_q, cls_dec;

  assign pc_rst_val = RESET_PC;
  assign state      = state_q;

  always_comb begin
    cls_dec = C_ILL;
    if (instr[31:15] == 17'b000000_0000_01_00000) cls_dec = C_ADD;
    else if (instr[31:22] == 10'b000000_1010)     cls_dec = C_ADDI;
    else if (instr[31:25] == 7'b000101_0)         cls_dec = C_LUI;
    else if (instr[31:22] == 10'b001010_0010)     cls_dec = C_LD;
    else if (instr[31:22] == 10'b001010_0110)     cls_dec = C_ST;
    else if (instr[31:26] == 6'b010111)           cls_dec = C_BNE;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:   state_d = S_ID;
      S_ID:   state_d = (cls_dec == C_ILL) ? S_HALT : S_EX;
      S_EX: begin
        if (cls_q == C_BNE)                        state_d = S_IF;
        else if (cls_q == C_LD || cls_q == C_ST)   state_d = S_MEM;
        else if (cls_q == C_ADD || cls_q == C_ADDI || cls_q == C_LUI) state_d = S_WB;
        else                                       state_d = S_IF;
      end
      S_MEM:  state_d = (cls_q == C_LD) ? S_WB : S_IF;
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      cls_q   <= C_ILL;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) cls_q <= cls_dec;
    end
  end

  // Strobes are gated by rst so nothing fires while reset is held, even in IF.
  always_comb begin
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    npc_sel = 1'b0;
    rf_we   = 1'b0;
    mem_we  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IF: ir_we = 1'b1;
        S_EX: if (cls_q == C_BNE) begin
          pc_we   = 1'b1;
          npc_sel = br_taken;
        end
        S_MEM: if (cls_q == C_ST) begin
          mem_we = 1'b1;
          pc_we  = 1'b1;
        end
        S_WB: begin
          rf_we = 1'b1;
          pc_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halted = (state_q == S_HALT);

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycles_q, instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_q  <= 32'h0;
      instret_q <= 32'h0;
    end else begin
      cycles_q  <= cycles_q + 32'd1;
      instret_q <= instret_q + {31'b0, pc_we};
    end
  end

  assign cycles  = cycles_q;
  assign instret = instret_q;
`else
  assign cycles  = 32'h0;
  assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl; expectations adapt to whether MC_PERF_CNT_EN is defined.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        br_taken = 1'b0;
  logic        ir_we, pc_we, npc_sel, rf_we, mem_we, halted;
  logic [2:0]  state;
  logic [31:0] pc_rst_val, instret, cycles;

  int n_chk = 0;
  int n_bad = 0;
  logic rf_seen, mem_seen, pc_seen;

`ifdef MC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  mc_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .br_taken(br_taken),
    .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel), .rf_we(rf_we),
    .mem_we(mem_we), .state(state), .halted(halted),
    .pc_rst_val(pc_rst_val), .instret(instret), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr_seen();
    rf_seen = 1'b0; mem_seen = 1'b0; pc_seen = 1'b0;
  endtask

  task automatic note();
    rf_seen  = rf_seen | rf_we;
    mem_seen = mem_seen | mem_we;
    pc_seen  = pc_seen | pc_we;
  endtask

  // Ends with rst released and sampling inside cycle 1.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    chk("rst_state", {29'b0, state}, 32'd0);
    chk("rst_ir_we", {31'b0, ir_we}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    clr_seen();
    note();
  endtask

  task automatic next_cyc();
    @(posedge clk); #2;
    note();
  endtask

  initial begin
    chk("pc_rst_val", pc_rst_val, 32'h1c00_0000);

    // ALU: addi.w r1,r0,5
    instr = 32'h0280_1401;
    do_reset();
    chk("alu_c1_state", {29'b0, state}, 32'd0);
    chk("alu_c1_ir_we", {31'b0, ir_we}, 32'd1);
    br_taken = 1'b1;
    chk("alu_c1_npc", {31'b0, npc_sel}, 32'd0);
    next_cyc();
    chk("alu_c2_state", {29'b0, state}, 32'd1);
    chk("alu_c2_ir_we", {31'b0, ir_we}, 32'd0);
    next_cyc();
    instr = 32'hFFFF_FFFF; // IR change after ID must be ignored
    br_taken = 1'b0;
    chk("alu_c3_state", {29'b0, state}, 32'd2);
    chk("alu_c3_pc_we", {31'b0, pc_we}, 32'd0);
    next_cyc();
    br_taken = 1'b1;
    #1;
    chk("alu_c4_state", {29'b0, state}, 32'd4);
    chk("alu_c4_rf_we", {31'b0, rf_we}, 32'd1);
    chk("alu_c4_pc_we", {31'b0, pc_we}, 32'd1);
    chk("alu_c4_npc", {31'b0, npc_sel}, 32'd0);
    chk("alu_c4_mem_we", {31'b0, mem_we}, 32'd0);
    chk("alu_c4_instret", instret, 32'd0);
    br_taken = 1'b0;
    next_cyc();
    chk("alu_c5_state", {29'b0, state}, 32'd0);
    chk("alu_c5_instret", instret, PERF ? 32'd1 : 32'd0);
    chk("alu_c5_cycles", cycles, PERF ? 32'd4 : 32'd0);
    chk("alu_mem_never", {31'b0, mem_seen}, 32'd0);

    // Load
    instr = 32'h2880_0020;
    do_reset();
    next_cyc();
    next_cyc();
    chk("ld_c3_state", {29'b0, state}, 32'd2);
    next_cyc();
    chk("ld_c4_state", {29'b0, state}, 32'd3);
    chk("ld_c4_rf_we", {31'b0, rf_we}, 32'd0);
    chk("ld_c4_pc_we", {31'b0, pc_we}, 32'd0);
    next_cyc();
    chk("ld_c5_state", {29'b0, state}, 32'd4);
    chk("ld_c5_rf_we", {31'b0, rf_we}, 32'd1);
    chk("ld_c5_pc_we", {31'b0, pc_we}, 32'd1);
    next_cyc();
    chk("ld_c6_state", {29'b0, state}, 32'd0);
    chk("ld_mem_never", {31'b0, mem_seen}, 32'd0);

    // Store
    instr = 32'h2980_0020;
    do_reset();
    next_cyc();
    next_cyc();
    next_cyc();
    chk("st_c4_state", {29'b0, state}, 32'd3);
    chk("st_c4_mem_we", {31'b0, mem_we}, 32'd1);
    chk("st_c4_pc_we", {31'b0, pc_we}, 32'd1);
    chk("st_c4_npc", {31'b0, npc_sel}, 32'd0);
    next_cyc();
    chk("st_c5_state", {29'b0, state}, 32'd0);
    chk("st_rf_never", {31'b0, rf_seen}, 32'd0);

    // BNE taken, with br_taken toggled in IF/ID
    instr = 32'h5C00_0820;
    do_reset();
    br_taken = 1'b1;
    #1;
    chk("bne_c1_npc", {31'b0, npc_sel}, 32'd0);
    next_cyc();
    chk("bne_c2_npc", {31'b0, npc_sel}, 32'd0);
    chk("bne_c2_pc_we", {31'b0, pc_we}, 32'd0);
    next_cyc();
    chk("bne_t_state", {29'b0, state}, 32'd2);
    chk("bne_t_pc_we", {31'b0, pc_we}, 32'd1);
    chk("bne_t_npc", {31'b0, npc_sel}, 32'd1);
    br_taken = 1'b0;
    #1;
    chk("bne_comb_npc", {31'b0, npc_sel}, 32'd0);
    next_cyc();
    chk("bne_t_after", {29'b0, state}, 32'd0);
    chk("bne_rf_never", {31'b0, rf_seen}, 32'd0);
    // second pass, not taken
    next_cyc();
    next_cyc();
    chk("bne_nt_pc_we", {31'b0, pc_we}, 32'd1);
    chk("bne_nt_npc", {31'b0, npc_sel}, 32'd0);
    next_cyc();
    chk("bne_instret", instret, PERF ? 32'd2 : 32'd0);

    // Illegal instruction
    instr = 32'hFFFF_FFFF;
    do_reset();
    next_cyc();
    next_cyc();
    chk("ill_state", {29'b0, state}, 32'd5);
    chk("ill_halted", {31'b0, halted}, 32'd1);
    instr = 32'h0280_1401;
    br_taken = 1'b1;
    for (int i = 0; i < 100; i++) next_cyc();
    chk("ill_still", {29'b0, state}, 32'd5);
    chk("ill_pc_never", {31'b0, pc_seen}, 32'd0);
    chk("ill_cycles", cycles, PERF ? 32'd102 : 32'd0);
    chk("ill_instret", instret, 32'd0);
    br_taken = 1'b0;
    do_reset();
    chk("ill_clr_state", {29'b0, state}, 32'd0);
    chk("ill_clr_halted", {31'b0, halted}, 32'd0);

    // Mid-op reset during MEM of ld.w (do_reset left us in cycle 1 of an addi)
    instr = 32'h2880_0020;
    do_reset();
    next_cyc();
    next_cyc();
    next_cyc();
    chk("mid_mem_state", {29'b0, state}, 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_state", {29'b0, state}, 32'd0);
    chk("mid_strobes", {27'b0, ir_we, pc_we, npc_sel, rf_we, mem_we}, 32'd0);
    @(posedge clk); #2;
    note();
    chk("mid_hold_strb", {27'b0, ir_we, pc_we, npc_sel, rf_we, mem_we}, 32'd0);
    rst = 1'b0;
    #1;
    note();
    chk("mid_rel_state", {29'b0, state}, 32'd0);
    chk("mid_rel_ir_we", {31'b0, ir_we}, 32'd1);
    chk("mid_rel_cycles", cycles, 32'd0);
    chk("mid_rel_instret", instret, 32'd0);
    chk("mid_rf_never", {31'b0, rf_seen}, 32'd0);
    next_cyc();
    chk("mid_restart_id", {29'b0, state}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
